// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pc_seq_pkg
// Description : Shared types and constants for the PC fetch sequencer.
//               Provides the sequencer state enum, the FaultCode encodings
//               and the sequential PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_HALTED  = 3'd4,
    ST_FAULT   = 3'd5
  } seq_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_MISALIGN = 2'b10;

  localparam logic [63:0] PC_INC = 64'd4;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_calc
// Description : Combinational next-PC selection. The unconditional branch
//               wins over the conditional one; all sums wrap modulo 2^64.
// Ports       : pc            in  64  PC of the resolving instruction
//               imm           in  64  sign-extended byte offset
//               branch        in  1   conditional branch instruction
//               alu_zero      in  1   ALU zero flag (condition met)
//               uncond_branch in  1   unconditional branch instruction
//               next_pc       out 64  selected next PC
//               misaligned    out 1   next_pc not word aligned
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc
  import pc_seq_pkg::*;
(
  input  logic [63:0] pc,
  input  logic [63:0] imm,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        uncond_branch,
  output logic [63:0] next_pc,
  output logic        misaligned
);

  logic take_branch;

  always_comb begin
    take_branch = uncond_branch | (branch & alu_zero);
    next_pc     = take_branch ? (pc + imm) : (pc + PC_INC);
    misaligned  = |next_pc[1:0];
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Single-issue instruction fetch sequencer. Boots from
//               StartPC, fetches one word at a time, hands it to decode and
//               waits for execute to resolve it before updating the PC.
//               Fetch timeouts and misaligned branch targets raise a sticky
//               fault that only reset clears.
// Ports       : CLK           in  1        rising-edge clock
//               resetl        in  1        asynchronous active-low reset
//               StartPC       in  64       boot address
//               IMemReq       out 1        fetch request
//               IMemAddr      out 64       fetch address (= PC)
//               IMemAck       in  1        fetch complete
//               IMemData      in  32       fetched instruction word
//               Instruction   out 32       latched instruction
//               InstValid     out 1        Instruction valid for issue
//               InstReady     in  1        decode accepts Instruction
//               ResolveValid  in  1        execute resolved instruction
//               Branch        in  1        conditional branch
//               ALUZero       in  1        branch condition met
//               Uncondbranch  in  1        unconditional branch
//               SignExtImm64  in  64       branch byte offset
//               Halt          in  1        stop after current retire
//               CurrentPC     out 64       PC register
//               RetireCount   out RETIRE_W retired-instruction count
//               Fault         out 1        sticky fault flag
//               FaultCode     out 2        01 timeout, 10 misaligned
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int RETIRE_W      = 32
) (
  input  logic                CLK,
  input  logic                resetl,
  input  logic [63:0]         StartPC,
  output logic                IMemReq,
  output logic [63:0]         IMemAddr,
  input  logic                IMemAck,
  input  logic [31:0]         IMemData,
  output logic [31:0]         Instruction,
  output logic                InstValid,
  input  logic                InstReady,
  input  logic                ResolveValid,
  input  logic                Branch,
  input  logic                ALUZero,
  input  logic                Uncondbranch,
  input  logic [63:0]         SignExtImm64,
  input  logic                Halt,
  output logic [63:0]         CurrentPC,
  output logic [RETIRE_W-1:0] RetireCount,
  output logic                Fault,
  output logic [1:0]          FaultCode
);

  // The counter only ever holds 0..FETCH_TIMEOUT-1: the cycle it would
  // reach FETCH_TIMEOUT is the cycle the FSM leaves FETCH.
  localparam int              TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  seq_state_e          state;
  seq_state_e          state_nxt;
  logic [63:0]         pc;
  logic [31:0]         instr;
  logic [RETIRE_W-1:0] retire_cnt;
  logic                fault;
  logic [1:0]          fault_code;
  logic [TO_W-1:0]     to_cnt;

  logic [63:0]         next_pc;
  logic                next_pc_misaligned;

  logic                fetch_done;
  logic                fetch_timeout;
  logic                resolve_ok;
  logic                resolve_bad;

  next_pc_calc u_next_pc_calc (
    .pc            (pc),
    .imm           (SignExtImm64),
    .branch        (Branch),
    .alu_zero      (ALUZero),
    .uncond_branch (Uncondbranch),
    .next_pc       (next_pc),
    .misaligned    (next_pc_misaligned)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    IMemReq       = 1'b0;
    InstValid     = 1'b0;
    fetch_done    = 1'b0;
    fetch_timeout = 1'b0;
    resolve_ok    = 1'b0;
    resolve_bad   = 1'b0;

    case (state)
      ST_BOOT: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        IMemReq = 1'b1;
        if (IMemAck) begin
          fetch_done = 1'b1;
          state_nxt  = ST_ISSUE;
        end else if (to_cnt == TO_LAST) begin
          fetch_timeout = 1'b1;
          state_nxt     = ST_FAULT;
        end
      end

      ST_ISSUE: begin
        InstValid = 1'b1;
        if (InstReady) begin
          state_nxt = ST_RESOLVE;
        end
      end

      ST_RESOLVE: begin
        if (ResolveValid) begin
          if (next_pc_misaligned) begin
            resolve_bad = 1'b1;
            state_nxt   = ST_FAULT;
          end else begin
            resolve_ok = 1'b1;
            state_nxt  = Halt ? ST_HALTED : ST_FETCH;
          end
        end
      end

      ST_HALTED: begin
        if (!Halt) begin
          state_nxt = ST_FETCH;
        end
      end

      ST_FAULT: begin
        state_nxt = ST_FAULT;
      end

      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // PC, instruction latch, retire counter, fault flags, fetch timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc         <= 64'd0;
      instr      <= 32'd0;
      retire_cnt <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      to_cnt     <= '0;
    end else begin
      if (state == ST_BOOT) begin
        pc <= StartPC;
      end

      if (fetch_done) begin
        instr <= IMemData;
      end

      if (resolve_ok) begin
        pc         <= next_pc;
        retire_cnt <= retire_cnt + RETIRE_W'(1);
      end

      if (fetch_timeout) begin
        fault      <= 1'b1;
        fault_code <= FC_TIMEOUT;
      end

      if (resolve_bad) begin
        fault      <= 1'b1;
        fault_code <= FC_MISALIGN;
      end

      // Counts only while staying in FETCH, so every entry starts from zero.
      if ((state == ST_FETCH) && (state_nxt == ST_FETCH)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign IMemAddr    = pc;
  assign CurrentPC   = pc;
  assign Instruction = instr;
  assign RetireCount = retire_cnt;
  assign Fault       = fault;
  assign FaultCode   = fault_code;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Self-checking bench for pc_fetch_sequencer. Drives whole
//               fetch/issue/resolve transactions and compares the DUT with
//               an architectural model (PC, retire count, fault state).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam int FETCH_TIMEOUT = 16;
  localparam int RETIRE_W      = 32;

  logic                CLK = 1'b0;
  logic                resetl = 1'b0;
  logic [63:0]         StartPC = 64'd0;
  logic                IMemReq;
  logic [63:0]         IMemAddr;
  logic                IMemAck = 1'b0;
  logic [31:0]         IMemData = 32'd0;
  logic [31:0]         Instruction;
  logic                InstValid;
  logic                InstReady = 1'b0;
  logic                ResolveValid = 1'b0;
  logic                Branch = 1'b0;
  logic                ALUZero = 1'b0;
  logic                Uncondbranch = 1'b0;
  logic [63:0]         SignExtImm64 = 64'd0;
  logic                Halt = 1'b0;
  logic [63:0]         CurrentPC;
  logic [RETIRE_W-1:0] RetireCount;
  logic                Fault;
  logic [1:0]          FaultCode;

  always #5 CLK = ~CLK;

  pc_fetch_sequencer #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT),
    .RETIRE_W      (RETIRE_W)
  ) dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .StartPC      (StartPC),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemData     (IMemData),
    .Instruction  (Instruction),
    .InstValid    (InstValid),
    .InstReady    (InstReady),
    .ResolveValid (ResolveValid),
    .Branch       (Branch),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .SignExtImm64 (SignExtImm64),
    .Halt         (Halt),
    .CurrentPC    (CurrentPC),
    .RetireCount  (RetireCount),
    .Fault        (Fault),
    .FaultCode    (FaultCode)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model
  logic [63:0]         m_pc;
  logic [31:0]         m_instr;
  logic [RETIRE_W-1:0] m_retire;
  logic                m_fault;
  logic [1:0]          m_code;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_arch(input string tag);
    check({tag, ":pc"},    CurrentPC,            m_pc);
    check({tag, ":instr"}, 64'(Instruction),     64'(m_instr));
    check({tag, ":ret"},   64'(RetireCount),     64'(m_retire));
    check({tag, ":fault"}, 64'(Fault),           64'(m_fault));
    check({tag, ":code"},  64'(FaultCode),       64'(m_code));
  endtask

  task automatic check_hs(input string tag, input logic req, input logic vld);
    check({tag, ":req"}, 64'(IMemReq),   64'(req));
    check({tag, ":vld"}, 64'(InstValid), 64'(vld));
  endtask

  // Scramble inputs that the current phase must ignore.
  task automatic junk_flags();
    Branch       = 1'($urandom);
    ALUZero      = 1'($urandom);
    Uncondbranch = 1'($urandom);
    SignExtImm64 = {$urandom, $urandom};
  endtask

  task automatic do_reset(input logic [63:0] start);
    resetl       = 1'b0;
    IMemAck      = 1'b0;
    InstReady    = 1'b0;
    ResolveValid = 1'b0;
    Halt         = 1'b0;
    StartPC      = start;
    #1;
    m_pc = 64'd0; m_instr = 32'd0; m_retire = '0; m_fault = 1'b0; m_code = 2'b00;
    check_arch("rst");
    check_hs("rst", 1'b0, 1'b0);
    tick();
    resetl   = 1'b1;
    IMemAck  = 1'b1;            // must be ignored while booting
    IMemData = $urandom;
    tick();
    IMemAck = 1'b0;
    m_pc    = start;
    check("boot:addr", IMemAddr, start);
    check_hs("boot", 1'b1, 1'b0);
    check_arch("boot");
  endtask

  task automatic do_fetch(input int delay, input logic [31:0] data);
    for (int i = 0; i < delay; i++) begin
      IMemAck      = 1'b0;
      Halt         = 1'($urandom);
      InstReady    = 1'($urandom);
      ResolveValid = 1'($urandom);
      junk_flags();
      check("fetch:addr", IMemAddr, m_pc);
      check_hs("fetch", 1'b1, 1'b0);
      tick();
    end
    IMemAck  = 1'b1;
    IMemData = data;
    check("fetch:addr", IMemAddr, m_pc);
    tick();
    IMemAck      = 1'b0;
    InstReady    = 1'b0;
    ResolveValid = 1'b0;
    Halt         = 1'b0;
    m_instr      = data;
    check_hs("issue", 1'b0, 1'b1);
    check_arch("issue");
  endtask

  task automatic do_issue(input int delay);
    for (int i = 0; i < delay; i++) begin
      InstReady = 1'b0;
      IMemAck   = 1'($urandom);
      IMemData  = $urandom;
      junk_flags();
      check_hs("issue_w", 1'b0, 1'b1);
      check("issue_w:instr", 64'(Instruction), 64'(m_instr));
      tick();
    end
    InstReady = 1'b1;
    IMemAck   = 1'b0;
    tick();
    InstReady = 1'b0;
    check_hs("resolve", 1'b0, 1'b0);
    check_arch("resolve");
  endtask

  task automatic do_resolve(input int delay, input logic br, input logic z, input logic un,
                            input logic [63:0] imm, input logic hlt);
    logic [63:0] target;
    for (int i = 0; i < delay; i++) begin
      ResolveValid = 1'b0;
      junk_flags();
      check("res_w:pc", CurrentPC, m_pc);
      check_hs("res_w", 1'b0, 1'b0);
      tick();
    end
    ResolveValid = 1'b1;
    Branch       = br;
    ALUZero      = z;
    Uncondbranch = un;
    SignExtImm64 = imm;
    Halt         = hlt;
    // Taken when unconditional, or conditional with the zero flag set.
    if (un || (br && z)) target = m_pc + imm;
    else                 target = m_pc + 64'd4;
    if (target[1:0] != 2'b00) begin
      m_fault = 1'b1;
      m_code  = 2'b10;
    end else begin
      m_pc     = target;
      m_retire = m_retire + 1;
    end
    tick();
    ResolveValid = 1'b0;
    Branch = 1'b0; ALUZero = 1'b0; Uncondbranch = 1'b0;
    check_arch("retire");
    if (m_fault) begin
      check_hs("fault", 1'b0, 1'b0);
    end else if (hlt) begin
      for (int i = 0; i < 2; i++) begin
        IMemAck = 1'($urandom);
        check_hs("halted", 1'b0, 1'b0);
        check("halted:pc", CurrentPC, m_pc);
        tick();
      end
      IMemAck = 1'b0;
      Halt    = 1'b0;
      tick();
      check("resume:addr", IMemAddr, m_pc);
      check_hs("resume", 1'b1, 1'b0);
    end else begin
      check("next:addr", IMemAddr, m_pc);
      check_hs("next", 1'b1, 1'b0);
    end
  endtask

  task automatic check_frozen(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      IMemAck      = 1'($urandom);
      IMemData     = $urandom;
      InstReady    = 1'($urandom);
      ResolveValid = 1'($urandom);
      Halt         = 1'($urandom);
      junk_flags();
      tick();
      check_arch("frozen");
      check_hs("frozen", 1'b0, 1'b0);
    end
    IMemAck = 1'b0; InstReady = 1'b0; ResolveValid = 1'b0; Halt = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] imm;
    longint      off;

    // Straight-line fetch, ack after 2 waiting cycles
    do_reset(64'h1000);
    do_fetch(2, 32'hDEAD_0001);
    do_issue(0);
    do_resolve(0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    check("seq:addr", IMemAddr, 64'h1004);
    check("seq:ret", 64'(RetireCount), 64'd1);

    // Conditional branch taken backwards, then not taken
    do_reset(64'h1000);
    do_fetch(1, 32'h1111_2222);
    do_issue(1);
    do_resolve(1, 1'b1, 1'b1, 1'b0, -64'sd8, 1'b0);
    check("br_taken:addr", IMemAddr, 64'h0FF8);
    do_reset(64'h1000);
    do_fetch(0, 32'h3333_4444);
    do_issue(2);
    do_resolve(0, 1'b1, 1'b0, 1'b0, -64'sd8, 1'b0);
    check("br_not:addr", IMemAddr, 64'h1004);

    // Unconditional wins over a failing conditional
    do_reset(64'h2000);
    do_fetch(0, 32'h5555_6666);
    do_issue(0);
    do_resolve(0, 1'b1, 1'b0, 1'b1, 64'h40, 1'b0);
    check("uncond:addr", IMemAddr, 64'h2040);

    // Ack on the last permitted cycle is still accepted
    do_fetch(FETCH_TIMEOUT - 1, 32'h7777_8888);
    do_issue(0);
    do_resolve(0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);

    // Fetch timeout
    do_reset(64'h3000);
    for (int i = 0; i < FETCH_TIMEOUT; i++) begin
      IMemAck = 1'b0;
      check_hs("to_wait", 1'b1, 1'b0);
      tick();
    end
    m_fault = 1'b1;
    m_code  = 2'b01;
    check_arch("timeout");
    check_hs("timeout", 1'b0, 1'b0);
    check_frozen(4);

    // Misaligned branch target
    do_reset(64'h4000);
    do_fetch(1, 32'h9999_0000);
    do_issue(0);
    do_resolve(0, 1'b0, 1'b0, 1'b1, 64'h6, 1'b0);
    check("misalign:pc", CurrentPC, 64'h4000);
    check_frozen(3);

    // Reset while in ISSUE, then halt and resume
    do_reset(64'h5000);
    do_fetch(0, 32'hAAAA_BBBB);
    tick();
    do_reset(64'h6000);
    do_fetch(3, 32'hCCCC_DDDD);
    do_issue(1);
    do_resolve(2, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    do_fetch(0, 32'hEEEE_FFFF);
    do_issue(0);
    do_resolve(0, 1'b1, 1'b1, 1'b0, 64'h100, 1'b0);

    // Randomized instruction stream
    do_reset({$urandom, $urandom} & ~64'h3);
    for (int n = 0; n < 40; n++) begin
      off = longint'($urandom_range(0, 511)) - 256;
      imm = 64'(off * 4);
      if ($urandom_range(0, 7) == 0) imm = imm + 64'($urandom_range(1, 3));
      do_fetch(int'($urandom_range(0, FETCH_TIMEOUT - 1)), $urandom);
      do_issue(int'($urandom_range(0, 3)));
      do_resolve(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                 imm, ($urandom_range(0, 3) == 0));
      if (m_fault) begin
        check_frozen(2);
        do_reset({$urandom, $urandom} & ~64'h3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 16: max cycles IMemReq may wait for IMemAck before fault.
REQ-002 Parameter RETIRE_W, default 32: width of RetireCount.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 resetl  in  1  asynchronous active-low reset.
REQ-006 StartPC  in  64  boot address, loaded once after reset release.
REQ-007 IMemReq  out  1  fetch request, held until IMemAck.
REQ-008 IMemAddr  out  64  fetch address (equals PC).
REQ-009 IMemAck  in  1  fetch complete; IMemData valid this cycle.
REQ-010 IMemData  in  32  fetched instruction word.
REQ-011 Instruction  out  32  latched instruction to decode.
REQ-012 InstValid  out  1  Instruction valid for issue.
REQ-013 InstReady  in  1  decode accepts Instruction.
REQ-014 ResolveValid  in  1  execute has resolved current instruction.
REQ-015 Branch, ALUZero, Uncondbranch  in  1 each  branch resolution flags.
REQ-016 SignExtImm64  in  64  byte offset, sign-extended.
REQ-017 Halt  in  1  stop fetching after current instruction retires.
REQ-018 CurrentPC  out  64  PC of the instruction in flight.
REQ-019 RetireCount  out  RETIRE_W  retired-instruction count.
REQ-020 Fault  out  1  sticky fault flag; FaultCode  out  2  00 none, 01 fetch timeout, 10 misaligned target.

Function
REQ-021 States SHALL be BOOT, FETCH, ISSUE, RESOLVE, HALTED, FAULT.
REQ-022 BOOT: lasts exactly one cycle after reset release; PC <= StartPC; -> FETCH.
REQ-023 FETCH: IMemReq=1, IMemAddr=PC; on IMemAck, Instruction <= IMemData, -> ISSUE; Halt ignored here.
REQ-024 FETCH timeout counter SHALL clear on entry and increment each cycle without IMemAck; reaching FETCH_TIMEOUT -> FAULT, code 01, IMemReq drops the next cycle.
REQ-025 ISSUE: InstValid=1, Instruction stable; on InstReady -> RESOLVE (one-cycle handshake minimum).
REQ-026 RESOLVE: wait for ResolveValid; NextPC = PC+SignExtImm64 if Uncondbranch, else if Branch&&ALUZero, else PC+4.
REQ-027 Uncondbranch SHALL take priority over the conditional branch; all adds wrap modulo 2^64.
REQ-028 On ResolveValid with NextPC[1:0]!=0: PC unchanged, no retire, -> FAULT, code 10.
REQ-029 On ResolveValid with aligned NextPC: PC <= NextPC, RetireCount += 1 (wraps at 2^RETIRE_W), -> HALTED if Halt else FETCH.
REQ-030 HALTED: all handshake outputs 0; when Halt=0 -> FETCH at current PC.
REQ-031 FAULT: sticky until reset; IMemReq=0, InstValid=0, PC and RetireCount frozen.
REQ-032 Flags and SignExtImm64 SHALL be ignored outside RESOLVE; IMemAck outside FETCH ignored.
REQ-033 CurrentPC SHALL equal PC register at all times; Instruction-to-NextPC latency from IMemAck is at least 2 cycles.

Reset
REQ-034 resetl low SHALL immediately force state BOOT-pending, PC=0, Instruction=0, RetireCount=0, Fault=0, FaultCode=00, IMemReq=0, InstValid=0, timeout=0.
REQ-035 Reset mid-fetch SHALL abandon the outstanding request; an IMemAck arriving in BOOT is ignored.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state enum, FaultCode constants and PC_INC=4.
REQ-037 NextPC arithmetic SHALL live in combinational sub-module next_pc_calc; FSM, PC, counters in pc_fetch_sequencer.

Verification
REQ-038 StartPC=0x1000, ack after 2 cycles, no branch -> IMemAddr 0x1000 then 0x1004, RetireCount=1.
REQ-039 PC=0x1000, Branch=1, ALUZero=1, SignExtImm64=-8 -> next IMemAddr 0xFF8; ALUZero=0 -> 0x1004.
REQ-040 Branch=1, ALUZero=0, Uncondbranch=1, imm=0x40 at PC 0x2000 -> next PC 0x2040.
REQ-041 No IMemAck for 16 cycles -> Fault=1, FaultCode=01, IMemReq=0; later IMemAck has no effect.
REQ-042 imm=0x6 -> FaultCode=10, PC unchanged, RetireCount unchanged.
REQ-043 resetl pulsed low in ISSUE -> outputs cleared same cycle; after release BOOT reloads StartPC; Halt during RESOLVE -> HALTED, resume on Halt=0.
